// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   // Owner of the memory port in the previous cycle.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CPU       = 2'd1,
      DMA       = 2'd2,
      DMA_BURST = 2'd3
   } arb_state_t;

   // Which requester an outstanding read belongs to.
   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_tag_t;

   // Load/store size codes as seen by datamemory.
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;

   // Starvation counter width; covers STARVE_MAX up to 15.
   localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/dmem_grant_logic.sv
// Combinational grant decision between the CPU MEM stage and the DMA port.
module dmem_grant_logic
   import dmem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4
) (
   input  arb_state_t          i_state,
   input  logic                i_cpu_req,
   input  logic                i_dma_req,
   input  logic [STARVE_W-1:0] i_starve_cnt,
   output logic                o_cpu_win,
   output logic                o_dma_win
);

   localparam logic [STARVE_W-1:0] LP_STARVE_MAX = STARVE_W'(STARVE_MAX);

   // Burst ownership first, then CPU priority bounded by the starvation count.
   always_comb begin
      o_cpu_win = 1'b0;
      o_dma_win = 1'b0;
      if ((i_state == DMA_BURST) && i_dma_req) begin
         o_dma_win = 1'b1;
      end else if (i_cpu_req && i_dma_req) begin
         if (i_starve_cnt < LP_STARVE_MAX) begin
            o_cpu_win = 1'b1;
         end else begin
            o_dma_win = 1'b1;
         end
      end else begin
         o_cpu_win = i_cpu_req;
         o_dma_win = i_dma_req;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU MEM stage vs. DMA/loader port.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DM_ADDRESS = 9,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [DM_ADDRESS-1:0] cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wd,
   input  logic [2:0]            cpu_funct3,
   output logic                  cpu_stall,
   output logic [DATA_W-1:0]     cpu_rdata,
   output logic                  cpu_rvalid,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [DM_ADDRESS-1:0] dma_addr,
   input  logic [DATA_W-1:0]     dma_wd,
   input  logic                  dma_lock,
   output logic                  dma_gnt,
   output logic [DATA_W-1:0]     dma_rdata,
   output logic                  dma_rvalid,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [DM_ADDRESS-1:0] mem_a,
   output logic [DATA_W-1:0]     mem_wd,
   output logic [2:0]            mem_funct3,
   input  logic [DATA_W-1:0]     mem_rd
);

   localparam logic [STARVE_W-1:0] LP_STARVE_MAX = STARVE_W'(STARVE_MAX);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [STARVE_W-1:0] r_starve_cnt;
   logic [STARVE_W-1:0] w_starve_nxt;
   logic                w_cpu_win;
   logic                w_dma_win;
   logic                w_cpu_rd;
   logic                w_dma_rd;
   logic                r_rd_pend;
   req_tag_t            r_rd_tag;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_dma_rdata;
   logic                w_unused_addr_lsb;

   // DMA is word-only; its byte-offset bits never reach the memory.
   assign w_unused_addr_lsb = ^dma_addr[1:0];

   dmem_grant_logic #(
      .STARVE_MAX (STARVE_MAX)
   ) u_grant (
      .i_state      (r_state),
      .i_cpu_req    (cpu_req),
      .i_dma_req    (dma_req),
      .i_starve_cnt (r_starve_cnt),
      .o_cpu_win    (w_cpu_win),
      .o_dma_win    (w_dma_win)
   );

   assign dma_gnt   = w_dma_win;
   assign cpu_stall = cpu_req & ~w_cpu_win;
   assign w_cpu_rd  = w_cpu_win & ~cpu_we;
   assign w_dma_rd  = w_dma_win & ~dma_we;

   // Steer the winner's fields onto the memory port; idle port drives zeros.
   always_comb begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_a      = '0;
      mem_wd     = '0;
      mem_funct3 = 3'b000;
      if (w_cpu_win) begin
         mem_read   = ~cpu_we;
         mem_write  = cpu_we;
         mem_a      = cpu_addr;
         mem_wd     = cpu_wd;
         mem_funct3 = cpu_funct3;
      end else if (w_dma_win) begin
         mem_read   = ~dma_we;
         mem_write  = dma_we;
         mem_a      = {dma_addr[DM_ADDRESS-1:2], 2'b00};
         mem_wd     = dma_wd;
         mem_funct3 = F3_LW;
      end
   end

   // Next owner: lock turns a DMA grant into a burst that pins the port.
   always_comb begin
      w_state_nxt = IDLE;
      if (w_dma_win) begin
         w_state_nxt = dma_lock ? DMA_BURST : DMA;
      end else if (w_cpu_win) begin
         w_state_nxt = CPU;
      end
   end

   // Count CPU wins over a waiting DMA; any DMA win or idle DMA clears it.
   always_comb begin
      w_starve_nxt = r_starve_cnt;
      if (!dma_req || w_dma_win) begin
         w_starve_nxt = '0;
      end else if (w_cpu_win && (r_state != DMA_BURST) && (r_starve_cnt < LP_STARVE_MAX)) begin
         w_starve_nxt = r_starve_cnt + 1'b1;
      end
   end

   // Arbitration state and starvation counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // Tag the granted read so the returned data pulses on the right requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_pend <= 1'b0;
         r_rd_tag  <= REQ_CPU;
      end else begin
         r_rd_pend <= w_cpu_rd | w_dma_rd;
         if (w_cpu_rd || w_dma_rd) begin
            r_rd_tag <= w_dma_rd ? REQ_DMA : REQ_CPU;
         end
      end
   end

   // Capture read data into the issuing requester's register only.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         if (w_cpu_rd) begin
            r_cpu_rdata <= mem_rd;
         end
         if (w_dma_rd) begin
            r_dma_rdata <= mem_rd;
         end
      end
   end

   assign cpu_rdata  = r_cpu_rdata;
   assign dma_rdata  = r_dma_rdata;
   assign cpu_rvalid = r_rd_pend & (r_rd_tag == REQ_CPU);
   assign dma_rvalid = r_rd_pend & (r_rd_tag == REQ_DMA);

endmodule
